// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths and TX handshake state encoding for the uart host bridge
package uart_pkg;

    localparam int UART_FRAME_W = 10;
    localparam int UART_DATA_W  = 8;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_BUSY = 2'd2,
        TX_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through synchronous FIFO, pop frees a slot for a same-cycle push
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the level counter alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_host_bridge.sv
// rtl/uart_host_bridge.sv - CPU-side TX/RX buffering and handshake bridge to the uart top
module uart_host_bridge
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                          clk_CPU,
    input  logic                          RST,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [9:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic                          err_clr,
    output logic                          UART_WRITE,
    output logic [7:0]                    DATA_IN_Tx,
    input  logic                          IRQ_Tx,
    input  logic                          UART_AVAIL,
    input  logic [9:0]                    DATA_OUT_Rx,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          rx_overflow,
    output logic                          tx_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic irq_meta_q, irq_s_q, avail_meta_q, avail_s_q, avail_prev_q;

    tx_state_e              state_q, state_d;
    logic                   uart_write_q, uart_write_d;
    logic [UART_DATA_W-1:0] data_in_q, data_in_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   rx_overflow_q, rx_overflow_d;
    logic                   tx_timeout_q, tx_timeout_d;

    logic                   tx_push, tx_pop, tx_full, tx_empty;
    logic [UART_DATA_W-1:0] tx_head;
    logic                   rx_pop, rx_full, rx_empty, avail_rise;
    logic                   tmo_hit, rx_ovf_set;

    assign tx_push    = tx_valid && !tx_full;
    assign tx_ready   = !tx_full;
    assign rx_valid   = !rx_empty;
    assign rx_pop     = rx_ready && !rx_empty;
    assign avail_rise = avail_s_q && !avail_prev_q;
    assign rx_ovf_set = avail_rise && rx_full && !rx_pop;

    uart_sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk_CPU),
        .resetn    (RST),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    uart_sync_fifo #(.WIDTH(UART_FRAME_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk_CPU),
        .resetn    (RST),
        .push      (avail_rise),
        .push_data (DATA_OUT_Rx),
        .pop       (rx_pop),
        .head      (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    always_comb begin
        state_d      = state_q;
        uart_write_d = uart_write_q;
        data_in_d    = data_in_q;
        tmo_d        = tmo_q;
        tx_pop       = 1'b0;
        tmo_hit      = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!tx_empty && irq_s_q) begin
                    tx_pop       = 1'b1;
                    data_in_d    = tx_head;
                    uart_write_d = 1'b1;
                    tmo_d        = '0;
                    state_d      = TX_REQ;
                end
            end
            TX_REQ, TX_BUSY: begin
                // Timeout takes priority so a stuck uart always releases the bridge.
                if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    uart_write_d = 1'b0;
                    tmo_hit      = 1'b1;
                    state_d      = TX_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (state_q == TX_REQ && !irq_s_q) begin
                        uart_write_d = 1'b0;
                        state_d      = TX_BUSY;
                    end else if (state_q == TX_BUSY && irq_s_q) begin
                        state_d = TX_DONE;
                    end
                end
            end
            TX_DONE: state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
        rx_overflow_d = rx_ovf_set || (rx_overflow_q && !err_clr);
        tx_timeout_d  = tmo_hit || (tx_timeout_q && !err_clr);
    end

    always_ff @(posedge clk_CPU) begin
        if (!RST) begin
            irq_meta_q    <= 1'b0;
            irq_s_q       <= 1'b0;
            avail_meta_q  <= 1'b0;
            avail_s_q     <= 1'b0;
            avail_prev_q  <= 1'b0;
            state_q       <= TX_IDLE;
            uart_write_q  <= 1'b0;
            data_in_q     <= '0;
            tmo_q         <= '0;
            rx_overflow_q <= 1'b0;
            tx_timeout_q  <= 1'b0;
        end else begin
            irq_meta_q    <= IRQ_Tx;
            irq_s_q       <= irq_meta_q;
            avail_meta_q  <= UART_AVAIL;
            avail_s_q     <= avail_meta_q;
            avail_prev_q  <= avail_s_q;
            state_q       <= state_d;
            uart_write_q  <= uart_write_d;
            data_in_q     <= data_in_d;
            tmo_q         <= tmo_d;
            rx_overflow_q <= rx_overflow_d;
            tx_timeout_q  <= tx_timeout_d;
        end
    end

    assign UART_WRITE  = uart_write_q;
    assign DATA_IN_Tx  = data_in_q;
    assign rx_overflow = rx_overflow_q;
    assign tx_timeout  = tx_timeout_q;

endmodule

// File: tb/tb_uart_host_bridge.sv
// tb/tb_uart_host_bridge.sv - scoreboard bench for uart_host_bridge with a behavioural uart transmitter
module tb_uart_host_bridge;

    localparam int DEPTH = 8;
    localparam int TMO   = 32;

    logic       clk_CPU = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       UART_WRITE;
    logic [7:0] DATA_IN_Tx;
    logic       IRQ_Tx;
    logic       UART_AVAIL = 1'b0;
    logic [9:0] DATA_OUT_Rx = '0;
    logic [3:0] tx_level, rx_level;
    logic       rx_overflow, tx_timeout;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int uart_mode = 0;
    logic uw_prev = 1'b0;
    logic [7:0] tx_exp[$];
    logic [7:0] tx_obs[$];
    logic [9:0] rx_exp[$];

    uart_host_bridge #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk_CPU     (clk_CPU),
        .RST         (RST),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .err_clr     (err_clr),
        .UART_WRITE  (UART_WRITE),
        .DATA_IN_Tx  (DATA_IN_Tx),
        .IRQ_Tx      (IRQ_Tx),
        .UART_AVAIL  (UART_AVAIL),
        .DATA_OUT_Rx (DATA_OUT_Rx),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .rx_overflow (rx_overflow),
        .tx_timeout  (tx_timeout)
    );

    always #5 clk_CPU = ~clk_CPU;

    task automatic tick();
        @(posedge clk_CPU);
        #1;
    endtask

    // Uart transmitter: mode 0 handshakes, mode 1 stays busy, mode 2 is stuck idle.
    initial begin
        IRQ_Tx = 1'b1;
        forever begin
            tick();
            IRQ_Tx = (uart_mode == 1) ? 1'b0 : 1'b1;
            if (UART_WRITE && !uw_prev) begin
                tx_obs.push_back(DATA_IN_Tx);
                if (uart_mode == 0) begin
                    repeat (2) tick();
                    IRQ_Tx = 1'b0;
                    repeat (20) tick();
                    IRQ_Tx = 1'b1;
                end
            end
            uw_prev = UART_WRITE;
        end
    end

    task automatic push_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic rx_pulse(input logic [9:0] f);
        DATA_OUT_Rx = f;
        UART_AVAIL  = 1'b1;
        repeat (3) tick();
        UART_AVAIL  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) tick();
        check_cnt++; if (UART_WRITE !== 1'b0) $display("FAIL reset_uart_write: got %0h expected 0", UART_WRITE); else pass_cnt++;
        check_cnt++; if (DATA_IN_Tx !== 8'h00) $display("FAIL reset_data_in: got %0h expected 0", DATA_IN_Tx); else pass_cnt++;
        check_cnt++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %0h expected 1", tx_ready); else pass_cnt++;
        check_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %0h expected 0", rx_valid); else pass_cnt++;
        check_cnt++; if (tx_level !== 4'd0 || rx_level !== 4'd0) $display("FAIL reset_levels: got %0d/%0d expected 0/0", tx_level, rx_level); else pass_cnt++;
        check_cnt++; if (rx_overflow !== 1'b0 || tx_timeout !== 1'b0) $display("FAIL reset_flags: got %0h/%0h expected 0/0", rx_overflow, tx_timeout); else pass_cnt++;
        RST = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_tx_burst();
        logic [7:0] e, o;
        uart_mode = 0;
        repeat (3) tick();
        tx_obs.delete();
        tx_valid = 1'b1;
        tx_data = 8'h55; tx_exp.push_back(8'h55); tick();
        check_cnt++; if (UART_WRITE !== 1'b0) $display("FAIL latency_early: got %0h expected 0", UART_WRITE); else pass_cnt++;
        tx_data = 8'hA3; tx_exp.push_back(8'hA3); tick();
        check_cnt++; if (UART_WRITE !== 1'b1) $display("FAIL latency_n2: got %0h expected 1", UART_WRITE); else pass_cnt++;
        tx_data = 8'h0F; tx_exp.push_back(8'h0F); tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 400 && tx_obs.size() < 3; i++) tick();
        repeat (40) tick();
        check_cnt++; if (tx_obs.size() != 3) $display("FAIL burst_write_count: got %0d expected 3", tx_obs.size()); else pass_cnt++;
        while (tx_exp.size() > 0) begin
            e = tx_exp.pop_front();
            o = (tx_obs.size() > 0) ? tx_obs.pop_front() : 8'hxx;
            check_cnt++; if (o !== e) $display("FAIL burst_byte: got %0h expected %0h", o, e); else pass_cnt++;
        end
        check_cnt++; if (tx_level !== 4'd0) $display("FAIL burst_level: got %0d expected 0", tx_level); else pass_cnt++;
    endtask

    task automatic test_tx_full();
        logic [7:0] e, o;
        logic pre_ready;
        uart_mode = 1;
        repeat (4) tick();
        tx_obs.delete();
        for (int i = 0; i <= DEPTH; i++) begin
            pre_ready = tx_ready;
            if (i < DEPTH) tx_exp.push_back(8'(8'h10 + i * 7));
            push_tx(8'(8'h10 + i * 7));
            if (i == DEPTH - 1) begin
                check_cnt++; if (tx_ready !== 1'b0) $display("FAIL full_ready_after_8: got %0h expected 0", tx_ready); else pass_cnt++;
            end
            if (i == DEPTH) begin
                check_cnt++; if (pre_ready !== 1'b0) $display("FAIL full_ninth_ready: got %0h expected 0", pre_ready); else pass_cnt++;
            end
        end
        check_cnt++; if (tx_level !== 4'd8) $display("FAIL full_level: got %0d expected 8", tx_level); else pass_cnt++;
        uart_mode = 0;
        for (int i = 0; i < 2000 && tx_obs.size() < DEPTH; i++) tick();
        repeat (40) tick();
        check_cnt++; if (tx_obs.size() != DEPTH) $display("FAIL full_drain_count: got %0d expected %0d", tx_obs.size(), DEPTH); else pass_cnt++;
        while (tx_exp.size() > 0) begin
            e = tx_exp.pop_front();
            o = (tx_obs.size() > 0) ? tx_obs.pop_front() : 8'hxx;
            check_cnt++; if (o !== e) $display("FAIL full_drain_byte: got %0h expected %0h", o, e); else pass_cnt++;
        end
    endtask

    task automatic test_rx_overflow();
        logic [9:0] e;
        rx_ready = 1'b0;
        rx_exp.delete();
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) rx_exp.push_back(10'(10'h100 + i * 13));
            rx_pulse(10'(10'h100 + i * 13));
        end
        check_cnt++; if (rx_level !== 4'd8) $display("FAIL ovf_level: got %0d expected 8", rx_level); else pass_cnt++;
        check_cnt++; if (rx_overflow !== 1'b1) $display("FAIL ovf_flag: got %0h expected 1", rx_overflow); else pass_cnt++;
        while (rx_exp.size() > 0) begin
            e = rx_exp.pop_front();
            check_cnt++; if (rx_valid !== 1'b1 || rx_data !== e) $display("FAIL ovf_drain: got %0h (valid %0h) expected %0h", rx_data, rx_valid, e); else pass_cnt++;
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        check_cnt++; if (rx_valid !== 1'b0 || rx_level !== 4'd0) $display("FAIL ovf_empty: got valid %0h level %0d expected 0/0", rx_valid, rx_level); else pass_cnt++;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check_cnt++; if (rx_overflow !== 1'b0) $display("FAIL ovf_clear: got %0h expected 0", rx_overflow); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int w, hi;
        logic [7:0] o;
        uart_mode = 2;
        repeat (3) tick();
        push_tx(8'h3C);
        w = 0;
        while (!UART_WRITE && w < 20) begin tick(); w++; end
        check_cnt++; if (w >= 20) $display("FAIL tmo_request: got no UART_WRITE expected request within 20 cycles"); else pass_cnt++;
        hi = 0;
        while (UART_WRITE && hi < 100) begin hi++; tick(); end
        check_cnt++; if (hi != TMO) $display("FAIL tmo_duration: got %0d expected %0d", hi, TMO); else pass_cnt++;
        check_cnt++; if (tx_timeout !== 1'b1) $display("FAIL tmo_flag: got %0h expected 1", tx_timeout); else pass_cnt++;
        uart_mode = 0;
        repeat (2) tick();
        tx_obs.delete();
        push_tx(8'h81);
        for (int i = 0; i < 200 && tx_obs.size() < 1; i++) tick();
        repeat (30) tick();
        o = (tx_obs.size() > 0) ? tx_obs.pop_front() : 8'hxx;
        check_cnt++; if (o !== 8'h81) $display("FAIL tmo_next_byte: got %0h expected 81", o); else pass_cnt++;
        check_cnt++; if (tx_timeout !== 1'b1) $display("FAIL tmo_sticky: got %0h expected 1", tx_timeout); else pass_cnt++;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check_cnt++; if (tx_timeout !== 1'b0) $display("FAIL tmo_clear: got %0h expected 0", tx_timeout); else pass_cnt++;
    endtask

    task automatic test_reset_mid_req();
        int w;
        logic seen;
        uart_mode = 2;
        repeat (3) tick();
        push_tx(8'hE7);
        push_tx(8'h42);
        w = 0;
        while (!UART_WRITE && w < 20) begin tick(); w++; end
        check_cnt++; if (UART_WRITE !== 1'b1) $display("FAIL midreq_request: got %0h expected 1", UART_WRITE); else pass_cnt++;
        RST = 1'b0; tick();
        check_cnt++; if (UART_WRITE !== 1'b0 || DATA_IN_Tx !== 8'h00) $display("FAIL midreq_drop: got %0h/%0h expected 0/0", UART_WRITE, DATA_IN_Tx); else pass_cnt++;
        check_cnt++; if (tx_level !== 4'd0) $display("FAIL midreq_level: got %0d expected 0", tx_level); else pass_cnt++;
        RST = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); if (UART_WRITE) seen = 1'b1; end
        check_cnt++; if (seen !== 1'b0) $display("FAIL midreq_idle: got %0h expected 0", seen); else pass_cnt++;
        tx_obs.delete();
        uart_mode = 0;
    endtask

    task automatic test_rx_full_push_pop();
        logic [9:0] e;
        rx_ready = 1'b0;
        rx_exp.delete();
        for (int i = 0; i < DEPTH; i++) begin
            rx_exp.push_back(10'(10'h3F0 - i * 29));
            rx_pulse(10'(10'h3F0 - i * 29));
        end
        check_cnt++; if (rx_level !== 4'd8) $display("FAIL pp_fill_level: got %0d expected 8", rx_level); else pass_cnt++;
        DATA_OUT_Rx = 10'h2AA;
        UART_AVAIL  = 1'b1;
        repeat (2) tick();
        e = rx_exp.pop_front();
        check_cnt++; if (rx_data !== e) $display("FAIL pp_head: got %0h expected %0h", rx_data, e); else pass_cnt++;
        rx_exp.push_back(10'h2AA);
        rx_ready = 1'b1;
        tick();
        rx_ready   = 1'b0;
        UART_AVAIL = 1'b0;
        repeat (3) tick();
        check_cnt++; if (rx_level !== 4'd8) $display("FAIL pp_level: got %0d expected 8", rx_level); else pass_cnt++;
        check_cnt++; if (rx_overflow !== 1'b0) $display("FAIL pp_no_overflow: got %0h expected 0", rx_overflow); else pass_cnt++;
        while (rx_exp.size() > 0) begin
            e = rx_exp.pop_front();
            check_cnt++; if (rx_valid !== 1'b1 || rx_data !== e) $display("FAIL pp_drain: got %0h (valid %0h) expected %0h", rx_data, rx_valid, e); else pass_cnt++;
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        check_cnt++; if (rx_level !== 4'd0) $display("FAIL pp_empty: got %0d expected 0", rx_level); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_tx_burst();
        test_tx_full();
        test_rx_overflow();
        test_timeout();
        test_reset_mid_req();
        test_rx_full_push_pop();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 50000 cycles");
        $fatal(1);
    end

endmodule
